// File: rtl/npu_pe_pkg.sv
// Shared definitions for the PE column tile: feed sequencer states, lane
// width, and the drain depth used by both the skew buffer and its feeder.
package npu_pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_CLR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feed_state_t;

    localparam int LANE_W = 16;

    // Deepest skew, latency*(rows-1), plus one MAC latency to flush the last row.
    function automatic int drain_cycles(input int latency, input int rows);
        return latency * rows;
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for one PE column tile: loads weights, clears accumulators,
// streams ifmap vectors into the skew buffer and waits for it to drain.
module systolic_feed_ctrl
    import npu_pe_pkg::*;
#(
    parameter int LATENCY = 9,
    parameter int ROWS    = 4,
    parameter int LEN_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     abort,
    input  logic                     src_valid,
    input  logic [LANE_W*ROWS-1:0]   src_data,
    output logic                     src_ready,
    output logic                     w_load,
    output logic [$clog2(ROWS)-1:0]  w_row,
    output logic                     acc_clr,
    output logic [LANE_W*ROWS-1:0]   ifmap_out,
    output logic                     ifmap_vld,
    output logic                     busy,
    output logic                     done
);

    localparam int DRAIN_CYC = drain_cycles(LATENCY, ROWS);
    localparam int CNT_W     = $clog2(DRAIN_CYC + 1);
    localparam int ROW_W     = $clog2(ROWS);
    localparam int DATA_W    = LANE_W * ROWS;

    feed_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   sent_q, sent_d;
    logic               xfer;

    logic               src_ready_d, w_load_d, acc_clr_d, ifmap_vld_d, busy_d, done_d;
    logic [ROW_W-1:0]   w_row_d;
    logic [DATA_W-1:0]  ifmap_out_d;

    // src_ready is a register that is high exactly in STREAM, so the
    // handshake never depends combinationally on src_valid.
    assign xfer = src_valid && src_ready;

    // Next-state, counter and next-output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sent_d  = sent_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && (cfg_len != '0)) begin
                    len_d   = cfg_len;
                    sent_d  = '0;
                    cnt_d   = CNT_W'(ROWS - 1);
                    state_d = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (cnt_q == '0) state_d = ST_CLR;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_CLR: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (xfer) begin
                    sent_d = sent_q + 1'b1;
                    if (sent_d == len_q) begin
                        // The shared down-counter is reloaded with DRAIN_CYC, so
                        // DRAIN lasts DRAIN_CYC+1 cycles: the first one is spent
                        // with the final beat still in the ifmap_out register.
                        cnt_d   = CNT_W'(DRAIN_CYC);
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sent_d  = '0;
        end

        src_ready_d = (state_d == ST_STREAM);
        w_load_d    = (state_d == ST_LOAD_W);
        w_row_d     = w_load_d ? ROW_W'(ROWS - 1 - int'(cnt_d)) : '0;
        acc_clr_d   = (state_d == ST_CLR);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);

        // Bubbles and drain cycles push zeros so the skew buffer stays clean.
        ifmap_vld_d = xfer && !abort;
        ifmap_out_d = ifmap_vld_d ? src_data : '0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: rst_n is used only as the asynchronous clear; it never appears in the next-state logic.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            sent_q    <= '0;
            src_ready <= 1'b0;
            w_load    <= 1'b0;
            w_row     <= '0;
            acc_clr   <= 1'b0;
            ifmap_out <= '0;
            ifmap_vld <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            sent_q    <= sent_d;
            src_ready <= src_ready_d;
            w_load    <= w_load_d;
            w_row     <= w_row_d;
            acc_clr   <= acc_clr_d;
            ifmap_out <= ifmap_out_d;
            ifmap_vld <= ifmap_vld_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed testbench for systolic_feed_ctrl at default parameters.
module tb_systolic_feed_ctrl;

    localparam int ROWS   = 4;
    localparam int LEN_W  = 16;
    localparam int DATA_W = 64;
    localparam int DONE_GAP = 37;   // done is DRAIN_CYC+1 = 37 cycles after the last beat

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic              abort;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              w_load;
    logic [1:0]        w_row;
    logic              acc_clr;
    logic [DATA_W-1:0] ifmap_out;
    logic              ifmap_vld;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    systolic_feed_ctrl #(.LATENCY(9), .ROWS(ROWS), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .abort     (abort),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .w_load    (w_load),
        .w_row     (w_row),
        .acc_clr   (acc_clr),
        .ifmap_out (ifmap_out),
        .ifmap_vld (ifmap_vld),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat b: lanes {b+3, b+2, b+1, b}; beat 1 = 0x0004_0003_0002_0001.
    function automatic logic [63:0] vec(input int b);
        return {16'(b + 3), 16'(b + 2), 16'(b + 1), 16'(b)};
    endfunction

    // Accept a start and advance to the first STREAM cycle.
    task automatic start_run(input int len);
        start   = 1'b1;
        cfg_len = LEN_W'(len);
        tick();
        start   = 1'b0;
        repeat (ROWS + 1) tick();
    endtask

    // Count cycles until done is observed (0 if it never comes); also
    // count any ifmap_vld cycles seen on the way.
    task automatic wait_done(output int cyc, output int vld_seen);
        cyc      = 0;
        vld_seen = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (ifmap_vld) vld_seen++;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int vld_seen;
        int act;
        logic [4:0] pat;

        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        abort     = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;

        // ---------------- reset values ----------------
        #12;
        check("rst_busy",      busy,      0);
        check("rst_src_ready", src_ready, 0);
        check("rst_w_load",    w_load,    0);
        check("rst_w_row",     w_row,     0);
        check("rst_acc_clr",   acc_clr,   0);
        check("rst_ifmap_vld", ifmap_vld, 0);
        check("rst_ifmap_out", ifmap_out, 0);
        check("rst_done",      done,      0);
        rst_n = 1'b1;
        tick();

        // ---------------- basic run, len 4 ----------------
        start     = 1'b1;
        cfg_len   = 16'd4;
        src_valid = 1'b1;
        src_data  = vec(1);
        tick();
        start = 1'b0;
        check("basic_busy",   busy,   1);
        check("basic_wload0", w_load, 1);
        check("basic_wrow0",  w_row,  0);
        check("basic_rdy_lw", src_ready, 0);
        for (int i = 1; i < ROWS; i++) begin
            tick();
            check("basic_wload", w_load, 1);
            check("basic_wrow",  w_row,  i);
        end
        tick();
        check("basic_wload_off", w_load,  0);
        check("basic_acc_clr",   acc_clr, 1);
        check("basic_rdy_clr",   src_ready, 0);
        tick();
        check("basic_acc_clr_off", acc_clr,   0);
        check("basic_rdy_on",      src_ready, 1);
        check("basic_no_early_vld", ifmap_vld, 0);
        for (int b = 1; b <= 4; b++) begin
            tick();
            check("basic_vld",  ifmap_vld, 1);
            check("basic_data", ifmap_out, vec(b));
            check("basic_rdy",  src_ready, (b < 4) ? 1 : 0);
            src_data = vec(b + 1);
        end
        wait_done(cyc, vld_seen);
        check("basic_done_gap",  cyc,      DONE_GAP);
        check("basic_extra_vld", vld_seen, 0);
        check("basic_busy_done", busy,     1);
        tick();
        check("basic_done_off", done, 0);
        check("basic_busy_off", busy, 0);

        // ---------------- bubbles, len 3 ----------------
        src_valid = 1'b0;
        start_run(3);
        check("bub_rdy", src_ready, 1);
        pat = 5'b10101;   // bit i = src_valid on beat i
        for (int i = 0; i < 5; i++) begin
            src_valid = pat[i];
            src_data  = vec(10 + i);
            tick();
            check("bub_vld",  ifmap_vld, pat[i]);
            check("bub_data", ifmap_out, pat[i] ? vec(10 + i) : 64'd0);
        end
        check("bub_rdy_drop", src_ready, 0);
        src_valid = 1'b1;   // further valid must not be consumed
        wait_done(cyc, vld_seen);
        check("bub_done_gap",  cyc,      DONE_GAP);
        check("bub_extra_vld", vld_seen, 0);
        tick();

        // ---------------- zero length ----------------
        src_valid = 1'b0;
        start     = 1'b1;
        cfg_len   = 16'd0;
        tick();
        start = 1'b0;
        check("zero_busy",  busy,   0);
        check("zero_wload", w_load, 0);
        act = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy || w_load || done) act++;
        end
        check("zero_activity", act, 0);

        // ---------------- abort on 2nd STREAM beat ----------------
        src_valid = 1'b1;
        src_data  = vec(40);
        start_run(5);
        tick();
        check("abort_beat1", ifmap_vld, 1);
        abort    = 1'b1;
        src_data = vec(41);
        tick();
        abort = 1'b0;
        check("abort_busy", busy,      0);
        check("abort_rdy",  src_ready, 0);
        check("abort_vld",  ifmap_vld, 0);
        act = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (done || busy || ifmap_vld || src_ready) act++;
        end
        check("abort_quiet", act, 0);
        src_data = vec(20);
        start_run(2);
        tick();
        check("reab_vld1",  ifmap_vld, 1);
        check("reab_data1", ifmap_out, vec(20));
        src_data = vec(21);
        tick();
        check("reab_vld2",  ifmap_vld, 1);
        check("reab_data2", ifmap_out, vec(21));
        wait_done(cyc, vld_seen);
        check("reab_done_gap", cyc, DONE_GAP);
        tick();

        // ---------------- async reset mid-DRAIN ----------------
        src_data = vec(50);
        start_run(1);
        tick();
        check("ar_vld", ifmap_vld, 1);
        src_valid = 1'b0;
        repeat (10) tick();
        check("ar_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy",  busy,      0);
        check("ar_rdy",   src_ready, 0);
        check("ar_wload", w_load,    0);
        check("ar_wrow",  w_row,     0);
        check("ar_clr",   acc_clr,   0);
        check("ar_vld0",  ifmap_vld, 0);
        check("ar_data",  ifmap_out, 0);
        check("ar_done",  done,      0);
        #1;
        rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done || busy) act++;
        end
        check("ar_no_done", act, 0);

        // ---------------- start while busy and during DONE ----------------
        start   = 1'b1;
        cfg_len = 16'd2;
        tick();
        start   = 1'b1;
        cfg_len = 16'd7;
        tick();
        start = 1'b0;
        check("sb_wrow1", w_row, 1);
        repeat (ROWS) tick();
        check("sb_rdy", src_ready, 1);
        src_valid = 1'b1;
        src_data  = vec(30);
        tick();
        check("sb_data1", ifmap_out, vec(30));
        start    = 1'b1;
        cfg_len  = 16'd7;
        src_data = vec(31);
        tick();
        start = 1'b0;
        check("sb_data2",    ifmap_out, vec(31));
        check("sb_len_kept", src_ready, 0);
        wait_done(cyc, vld_seen);
        check("sb_done_gap",  cyc,      DONE_GAP);
        check("sb_extra_vld", vld_seen, 0);
        start   = 1'b1;
        cfg_len = 16'd7;
        tick();
        start = 1'b0;
        check("sd_busy",  busy,   0);
        check("sd_wload", w_load, 0);
        act = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done || busy) act++;
        end
        check("sd_single_done", act, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
